// File: rtl/four_bit_xor_descrambler.sv
// Receive-side nibble descrambler: XORs each accepted nibble with an x^4+x^3+1 LFSR keystream.
// Latency 1 cycle through a one-entry output register; in_ready = !full || out_ready (no in_valid path).
module four_bit_xor_descrambler #(
  parameter logic [3:0] SEED = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic [3:0] seed,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [7:0] nibble_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     r_state;
  logic [3:0] r_lfsr;
  logic [3:0] r_out_data;
  logic [7:0] r_cnt;

  logic       w_accept;
  logic       w_deliver;
  logic [3:0] w_seed_key;
  logic [3:0] w_key;
  logic [3:0] w_key_next;

  // A zero seed would lock the LFSR at zero, so it falls back to SEED.
  assign w_seed_key = (seed == 4'b0000) ? SEED : seed;
  assign w_key      = seed_load ? w_seed_key : r_lfsr;
  assign w_key_next = {w_key[2:0], w_key[3] ^ w_key[2]};

  assign out_valid  = (r_state == FULL);
  assign in_ready   = (r_state == EMPTY) || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_deliver  = out_valid && out_ready;
  assign out_data   = r_out_data;
  assign nibble_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (w_accept) begin
      r_lfsr <= w_key_next;
    end else if (seed_load) begin
      r_lfsr <= w_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_out_data <= 4'b0000;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state    <= FULL;
            r_out_data <= in_data ^ w_key;
          end
        end
        FULL: begin
          if (w_accept) begin
            r_out_data <= in_data ^ w_key;
          end else if (out_ready) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (w_deliver) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_four_bit_xor_descrambler.sv
// Bench for four_bit_xor_descrambler: vector table plus scoreboard queue of expected nibbles.
`timescale 1ns/1ps
module tb_four_bit_xor_descrambler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_load = 1'b0;
  logic [3:0] seed = 4'b0000;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'b0000;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [7:0] nibble_cnt;

  four_bit_xor_descrambler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .nibble_cnt (nibble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sl;
    logic [3:0] sd;
    logic       iv;
    logic [3:0] id;
    logic       ordy;
    logic [3:0] exp;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] sbq[$];
  logic       m_full;
  logic [3:0] m_lfsr;
  logic [7:0] m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  // One clock cycle: drive on the falling edge, check and update the model, then cross the rising edge.
  task automatic step(input logic sl, input logic [3:0] sd, input logic iv,
                      input logic [3:0] id, input logic ordy, input logic [3:0] exp);
    logic       acc;
    logic [3:0] key;
    @(negedge clk);
    chk("nibble_cnt", int'(nibble_cnt), int'(m_cnt));
    seed_load = sl; seed = sd; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    acc = iv && (!m_full || ordy);
    chk("in_ready", int'(in_ready), int'(!m_full || ordy));
    chk("out_valid", int'(out_valid), int'(m_full));
    if (m_full) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        chk("out_data", int'(out_data), int'(sbq[0]));
        if (ordy) begin
          void'(sbq.pop_front());
          m_cnt = m_cnt + 8'd1;
        end
      end
    end
    key = sl ? ((sd == 4'b0000) ? 4'b0001 : sd) : m_lfsr;
    if (acc) m_lfsr = nxt(key);
    else if (sl) m_lfsr = key;
    if (acc) sbq.push_back(exp);
    m_full = acc ? 1'b1 : (ordy ? 1'b0 : m_full);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_cnt", int'(nibble_cnt), 0);
    sbq.delete();
    m_full = 1'b0; m_lfsr = 4'b0001; m_cnt = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t       tbl_a[$];
  vec_t       tbl_c[$];
  logic [3:0] ks[16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic stream; the third nibble of 0000 exposes lfsr=0100.
    tbl_a.push_back('{1'b0, 4'h0, 1'b1, 4'b0011, 1'b1, 4'b0010});
    tbl_a.push_back('{1'b0, 4'h0, 1'b1, 4'b0101, 1'b1, 4'b0111});
    tbl_a.push_back('{1'b0, 4'h0, 1'b1, 4'b0000, 1'b1, 4'b0100});
    tbl_a.push_back('{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'b0000});

    // Stall, then seed_load cases (with accept, with zero seed, without accept, while held).
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b1111, 1'b1, 4'b1110});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0101, 1'b0, 4'b0000});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0101, 1'b0, 4'b0000});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0101, 1'b0, 4'b0000});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0101, 1'b1, 4'b0111});
    tbl_c.push_back('{1'b0, 4'h0,    1'b0, 4'b0000, 1'b1, 4'b0000});
    tbl_c.push_back('{1'b1, 4'b0000, 1'b1, 4'b1010, 1'b1, 4'b1011});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0000, 1'b1, 4'b0010});
    tbl_c.push_back('{1'b1, 4'b1000, 1'b1, 4'b1010, 1'b1, 4'b0010});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0000, 1'b1, 4'b0001});
    tbl_c.push_back('{1'b1, 4'b0110, 1'b0, 4'b0000, 1'b1, 4'b0000});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0000, 1'b1, 4'b0110});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0011, 1'b1, 4'b1110});
    tbl_c.push_back('{1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000});
    tbl_c.push_back('{1'b0, 4'h0,    1'b1, 4'b0000, 1'b1, 4'b0001});
    tbl_c.push_back('{1'b0, 4'h0,    1'b0, 4'b0000, 1'b1, 4'b0000});

    ks = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
           4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};

    m_full = 1'b0; m_lfsr = 4'b0001; m_cnt = 8'd0;

    do_reset();
    foreach (tbl_a[i]) step(tbl_a[i].sl, tbl_a[i].sd, tbl_a[i].iv, tbl_a[i].id, tbl_a[i].ordy, tbl_a[i].exp);
    @(negedge clk);
    chk("cnt_after_two_plus_one", int'(nibble_cnt), 3);

    // Full keystream period plus wrap.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 1'b1, 4'b0000, 1'b1, ks[i]);
    step(1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'b0000);

    do_reset();
    foreach (tbl_c[i]) step(tbl_c[i].sl, tbl_c[i].sd, tbl_c[i].iv, tbl_c[i].id, tbl_c[i].ordy, tbl_c[i].exp);

    // Counter wrap at 256 deliveries.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      step(1'b0, 4'h0, 1'b1, d, 1'b1, d ^ m_lfsr);
    end
    step(1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'b0000);
    @(negedge clk);
    chk("cnt_wrap_256", int'(nibble_cnt), 0);
    step(1'b0, 4'h0, 1'b1, 4'b1001, 1'b1, 4'b1001 ^ m_lfsr);
    step(1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'b0000);
    @(negedge clk);
    chk("cnt_257", int'(nibble_cnt), 1);

    // Asynchronous reset while holding a nibble under backpressure.
    do_reset();
    step(1'b0, 4'h0, 1'b1, 4'b0110, 1'b1, 4'b0111);
    step(1'b0, 4'h0, 1'b1, 4'b0000, 1'b0, 4'b0000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_cnt", int'(nibble_cnt), 0);
    chk("async_in_ready", int'(in_ready), 1);
    sbq.delete();
    m_full = 1'b0; m_lfsr = 4'b0001; m_cnt = 8'd0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'h0, 1'b1, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'b0000);
    @(negedge clk);
    chk("post_reset_cnt", int'(nibble_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/four_bit_xor_descrambler.md
# four_bit_xor_descrambler

Receive-side counterpart of the 4-bit XOR scrambler stage. It accepts scrambled 4-bit nibbles over a valid/ready handshake and XORs each one with a 4-bit LFSR keystream, recovering the plaintext nibble. It presents each result through a one-entry registered output stage and counts delivered nibbles. It sits between the link input and the nibble consumer, and shares seed and polynomial with the transmit-side scrambler so the two keystreams stay aligned.

## Interface
- SEED, 4'b0001, LFSR value loaded at reset and substituted for any zero seed; must be nonzero.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- seed_load  input  1  single-cycle pulse that reloads the LFSR from seed.
- seed  input  4  new LFSR value, sampled when seed_load=1; 4'b0000 is replaced by SEED.
- in_valid  input  1  in_data holds a scrambled nibble.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  4  scrambled nibble.
- out_valid  output  1  out_data holds a descrambled nibble.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  4  descrambled nibble.
- nibble_cnt  output  8  count of nibbles delivered (out_valid&&out_ready); wraps 255->0.

## Operation
- LFSR lfsr[3:0], Fibonacci, x^4+x^3+1: next = {lfsr[2:0], lfsr[3]^lfsr[2]}; period 15; never 0.
- Keystream for a nibble = LFSR value current at acceptance; LFSR advances exactly once per accepted nibble (in_valid&&in_ready), never otherwise.
- Accept: out_data <= in_data ^ key; out_valid <= 1.
- Output FSM, two states:
  - EMPTY: out_valid=0, in_ready=1; accept -> FULL.
  - FULL: out_valid=1, in_ready=out_ready. If out_ready and accept: stay FULL with new data. If out_ready and no accept: -> EMPTY. If !out_ready: hold out_data and stay FULL; no accept.
- out_data is stable while out_valid=1 and out_ready=0.
- seed_load priority: in the seed_load cycle, key = (seed==0 ? SEED : seed). A nibble accepted in that cycle is XORed with that key, and the LFSR becomes next(key). With no accept, the LFSR becomes key.
- seed_load never drops or alters a nibble already held in the output register.
- nibble_cnt increments by 1 on each out_valid&&out_ready; modulo 256.

## Timing
- Reset (rst_n=0, async): lfsr=SEED, FSM=EMPTY, out_valid=0, out_data=4'b0000, nibble_cnt=0, in_ready=1 combinationally after reset. All registers are released on the first clk edge after rst_n rises.
- Latency: a nibble accepted at edge N appears on out_data with out_valid=1 after edge N.
- in_ready is combinational from FSM state and out_ready; no combinational path from in_valid to any output.
- Throughput: 1 nibble/cycle when out_ready is held high.
- Reset asserted mid-stream: the held nibble is discarded, the count clears, and the keystream restarts from SEED.

## Test plan
- Reset, then 0011 and 0101 on consecutive cycles with out_ready=1 -> out_data 0010 then 0111 one cycle after each accept; lfsr = 0100; nibble_cnt=2.
- 15 nibbles of 0000 starting from reset -> out_data sequence 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000. The 16th nibble gives 0001 (wrap).
- Accept 1111 with out_ready=0 for 3 cycles while in_valid=1 -> out_data=1110 held, in_ready=0, lfsr not advanced, no second accept. Raising out_ready then gives a delivery plus a same-cycle accept.
- seed_load=1 with seed=0000 coincident with accepting 1010 -> key=SEED=0001, out_data=1011, lfsr=0010 afterwards. With seed=1000 -> out_data=0010, lfsr=0001.
- 256 delivered nibbles -> nibble_cnt returns to 0. The 257th delivery gives 1.
- rst_n pulsed low while FULL with out_ready=0 -> out_valid=0, nibble_cnt=0, lfsr=SEED immediately, without waiting for a clk edge. The next input uses key 0001.
